// File: rtl/clock_gate_enable_gen.sv
// Clock-enable generator: grants a requested number of ce-high cycles to a
// downstream clock gate, honouring stall/flush and counting granted cycles.
module clock_gate_enable_gen #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TOT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_cycles,
    input  logic             stall,
    input  logic             flush,
    output logic             ce,
    output logic             busy,
    output logic             done,
    output logic [TOT_W-1:0] granted_total
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              ce_d;
    logic              done_d;
    logic              rem_zero;
    logic              accept;
    logic              finishing;

    assign rem_zero  = (rem_q == '0);
    assign req_ready = !flush && ((state_q == IDLE) || rem_zero);
    assign accept    = req_valid && req_ready;
    assign finishing = (state_q == ACTIVE) && rem_zero;
    assign busy      = (state_q == ACTIVE);

    // ACTIVE with rem==0 means the last grant is on ce right now; a new
    // request accepted at that edge chains directly onto it.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ce_d    = 1'b0;
        done_d  = 1'b0;
        if (flush) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            if (finishing) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            if (accept) begin
                if (req_cycles == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ACTIVE;
                    if (stall) begin
                        rem_d = req_cycles;
                    end else begin
                        ce_d  = 1'b1;
                        rem_d = req_cycles - CNT_W'(1);
                    end
                end
            end else if ((state_q == ACTIVE) && !rem_zero && !stall) begin
                ce_d  = 1'b1;
                rem_d = rem_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            ce            <= 1'b0;
            done          <= 1'b0;
            granted_total <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ce      <= ce_d;
            done    <= done_d;
            if (ce) begin
                granted_total <= granted_total + TOT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_clock_gate_enable_gen.sv
// Bench for clock_gate_enable_gen: directed scenarios plus a randomized run
// compared cycle-by-cycle against a grant-accounting reference model.
module tb_clock_gate_enable_gen;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_cycles;
    logic        stall;
    logic        flush;
    logic        ce;
    logic        busy;
    logic        done;
    logic [31:0] granted_total;

    logic        s_ready, s_ce, s_busy, s_done;
    logic [3:0]  s_total;

    int total = 0;
    int bad   = 0;

    // reference model: grants owed, whether a request is live, last outputs
    int          m_owed;
    bit          m_busy, m_ce, m_done;
    int unsigned m_total;
    bit          exp_ready;
    logic        obs_ready;

    logic [31:0] ce_p, done_p, busy_p, rdy_p;

    clock_gate_enable_gen #(.CNT_W(16), .TOT_W(32)) u_dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cycles(req_cycles), .stall(stall), .flush(flush), .ce(ce), .busy(busy),
        .done(done), .granted_total(granted_total)
    );

    clock_gate_enable_gen #(.CNT_W(4), .TOT_W(4)) u_small (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(s_ready),
        .req_cycles(req_cycles[3:0]), .stall(stall), .flush(flush), .ce(s_ce), .busy(s_busy),
        .done(s_done), .granted_total(s_total)
    );

    always #5 clock = ~clock;

    task automatic model_step(input bit v, input int unsigned n, input bit st, input bit fl);
        bit acc, fin;
        if (m_ce) m_total++;
        if (fl) begin
            m_ce = 0; m_owed = 0; m_busy = 0; m_done = 0;
            return;
        end
        acc    = v && exp_ready;
        fin    = m_busy && (m_owed == 0);
        m_done = fin || (acc && n == 0);
        if (acc && n > 0) begin
            m_busy = 1;
            m_ce   = !st;
            m_owed = st ? int'(n) : int'(n) - 1;
        end else if (acc || fin) begin
            m_busy = 0;
            m_ce   = 0;
        end else if (m_busy && m_owed > 0 && !st) begin
            m_ce = 1;
            m_owed--;
        end else begin
            m_ce = 0;
        end
    endtask

    task automatic model_reset();
        m_owed = 0; m_busy = 0; m_ce = 0; m_done = 0; m_total = 0;
    endtask

    // drive one cycle: inputs set mid-cycle, ready sampled before the edge,
    // outputs left settled 1 time unit after the edge
    task automatic tick(input bit v, input int unsigned n, input bit st, input bit fl);
        req_valid  = v;
        req_cycles = 16'(n);
        stall      = st;
        flush      = fl;
        #1;
        obs_ready = req_ready;
        exp_ready = !fl && (!m_busy || m_owed == 0);
        @(posedge clock);
        model_step(v, n, st, fl);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_cycles = '0; stall = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clock);
        reset_n = 0;
        @(posedge clock);
        #2 reset_n = 1;
        model_reset();
        #1;
    endtask

    task automatic clear_rec();
        ce_p = '0; done_p = '0; busy_p = '0; rdy_p = '0;
    endtask

    task automatic record();
        ce_p   = {ce_p[30:0], ce};
        done_p = {done_p[30:0], done};
        busy_p = {busy_p[30:0], busy};
        rdy_p  = {rdy_p[30:0], obs_ready};
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clock);
        #2 reset_n = 0;
        #1;
        total++; if (ce !== 1'b0) begin bad++; $display("FAIL reset_ce: got %b want 0", ce); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (granted_total !== 32'd0) begin bad++; $display("FAIL reset_total: got %0d want 0", granted_total); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        do_reset();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_basic_n5();
        do_reset(); clear_rec();
        for (int i = 0; i < 7; i++) begin tick(i == 0, 5, 0, 0); record(); end
        total++; if (ce_p[6:0] !== 7'b1111100) begin bad++; $display("FAIL n5_ce: got %b want 1111100", ce_p[6:0]); end
        total++; if (done_p[6:0] !== 7'b0000010) begin bad++; $display("FAIL n5_done: got %b want 0000010", done_p[6:0]); end
        total++; if (granted_total !== 32'd5) begin bad++; $display("FAIL n5_total: got %0d want 5", granted_total); end
    endtask

    task automatic test_stall();
        do_reset(); clear_rec();
        for (int i = 0; i < 8; i++) begin tick(i == 0, 4, (i >= 2 && i <= 4), 0); record(); end
        total++; if (ce_p[7:0] !== 8'b11000110) begin bad++; $display("FAIL stall_ce: got %b want 11000110", ce_p[7:0]); end
        total++; if (done_p[7:0] !== 8'b00000001) begin bad++; $display("FAIL stall_done: got %b want 00000001", done_p[7:0]); end
        total++; if (busy_p[7:0] !== 8'b11111110) begin bad++; $display("FAIL stall_busy: got %b want 11111110", busy_p[7:0]); end
    endtask

    task automatic test_back_to_back();
        do_reset(); clear_rec();
        for (int i = 0; i < 6; i++) begin tick(i <= 3, (i == 0) ? 3 : 2, 0, 0); record(); end
        total++; if (ce_p[5:0] !== 6'b111110) begin bad++; $display("FAIL b2b_ce: got %b want 111110", ce_p[5:0]); end
        total++; if (done_p[5:0] !== 6'b000101) begin bad++; $display("FAIL b2b_done: got %b want 000101", done_p[5:0]); end
        total++; if (rdy_p[5:2] !== 4'b1001) begin bad++; $display("FAIL b2b_ready: got %b want 1001", rdy_p[5:2]); end
        total++; if (granted_total !== 32'd5) begin bad++; $display("FAIL b2b_total: got %0d want 5", granted_total); end
    endtask

    task automatic test_zero();
        do_reset(); clear_rec();
        for (int i = 0; i < 3; i++) begin tick(i == 0, 0, 0, 0); record(); end
        total++; if (ce_p[2:0] !== 3'b000) begin bad++; $display("FAIL zero_ce: got %b want 000", ce_p[2:0]); end
        total++; if (done_p[2:0] !== 3'b100) begin bad++; $display("FAIL zero_done: got %b want 100", done_p[2:0]); end
        total++; if (busy_p[2:0] !== 3'b000) begin bad++; $display("FAIL zero_busy: got %b want 000", busy_p[2:0]); end
    endtask

    task automatic test_flush();
        do_reset(); clear_rec();
        for (int i = 0; i < 8; i++) begin tick(i == 0, 10, 0, i == 4); record(); end
        total++; if (ce_p[7:0] !== 8'b11110000) begin bad++; $display("FAIL flush_ce: got %b want 11110000", ce_p[7:0]); end
        total++; if (done_p[7:0] !== 8'b00000000) begin bad++; $display("FAIL flush_done: got %b want 00000000", done_p[7:0]); end
        total++; if (rdy_p[3:2] !== 2'b01) begin bad++; $display("FAIL flush_ready: got %b want 01", rdy_p[3:2]); end
        total++; if (granted_total !== 32'd4) begin bad++; $display("FAIL flush_total: got %0d want 4", granted_total); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        do_reset(); clear_rec();
        for (int i = 0; i < 3; i++) tick(i == 0, 8, 0, 0);
        #2 reset_n = 0;
        #1;
        total++; if (ce !== 1'b0) begin bad++; $display("FAIL mid_reset_ce: got %b want 0", ce); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        total++; if (granted_total !== 32'd0) begin bad++; $display("FAIL mid_reset_total: got %0d want 0", granted_total); end
        @(posedge clock);
        #2 reset_n = 1;
        model_reset();
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %b want 1", req_ready); end
        for (int i = 0; i < 4; i++) begin tick(i == 0, 2, 0, 0); record(); end
        total++; if (ce_p[3:0] !== 4'b1100) begin bad++; $display("FAIL mid_reset_new_ce: got %b want 1100", ce_p[3:0]); end
        total++; if (done_p[3:0] !== 4'b0010) begin bad++; $display("FAIL mid_reset_done: got %b want 0010", done_p[3:0]); end
    endtask

    task automatic test_wrap_max();
        int s_ce_cnt = 0;
        int s_done_cnt = 0;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            tick(i <= 15, (i == 0) ? 15 : 2, 0, 0);
            s_ce_cnt   += int'(s_ce);
            s_done_cnt += int'(s_done);
        end
        total++; if (s_ce_cnt !== 17) begin bad++; $display("FAIL wrap_ce_count: got %0d want 17", s_ce_cnt); end
        total++; if (s_done_cnt !== 2) begin bad++; $display("FAIL wrap_done_count: got %0d want 2", s_done_cnt); end
        total++; if (s_total !== 4'd1) begin bad++; $display("FAIL wrap_total4: got %0d want 1", s_total); end
        total++; if (granted_total !== 32'd17) begin bad++; $display("FAIL wrap_total32: got %0d want 17", granted_total); end
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL wrap_busy: got %b want 0", s_busy); end
    endtask

    task automatic test_random();
        bit v, st, fl;
        int unsigned n;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            v  = ($urandom_range(0, 99) < 60);
            n  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 39) == 0);
            tick(v, n, st, fl);
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, obs_ready, exp_ready); end
            total++; if (ce !== m_ce) begin bad++; $display("FAIL rnd_ce[%0d]: got %b want %b", i, ce, m_ce); end
            total++; if (done !== m_done) begin bad++; $display("FAIL rnd_done[%0d]: got %b want %b", i, done, m_done); end
            total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, m_busy); end
            total++; if (granted_total !== m_total) begin bad++; $display("FAIL rnd_total[%0d]: got %0d want %0d", i, granted_total, m_total); end
        end
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_basic_n5();
        test_stall();
        test_back_to_back();
        test_zero();
        test_flush();
        test_reset_mid();
        test_wrap_max();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_gate_enable_gen.md
CLOCK_GATE_ENABLE_GEN -- requirements
Module: clock_gate_enable_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the cycle-request count.
REQ-002 SHALL have parameter TOT_W, default 32: width of the granted-cycle total counter.
REQ-003 clock  input  1  the single clock; all state SHALL be updated on its rising edge.
REQ-004 reset_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 req_valid  input  1  a cycle-grant request is present.
REQ-006 req_ready  output  1  the block can accept a request this cycle.
REQ-007 req_cycles  input  CNT_W  number of enabled cycles requested (unsigned).
REQ-008 stall  input  1  downstream pause; while sampled high, no new grant SHALL be issued.
REQ-009 flush  input  1  synchronous abort of the outstanding request.
REQ-010 ce  output  1  clock-enable to the downstream clock gate; SHALL be driven directly from a flop.
REQ-011 busy  output  1  a request is outstanding.
REQ-012 done  output  1  one-cycle completion pulse; SHALL be driven from a flop.
REQ-013 granted_total  output  TOT_W  count of ce-high cycles since reset.

Function
REQ-014 SHALL form a handshake on each rising edge where req_valid && req_ready; req_cycles is captured at that edge only.
REQ-015 State SHALL be IDLE (busy=0) or ACTIVE (busy=1); rem (CNT_W) SHALL hold the grants owed, not yet issued.
REQ-016 req_ready SHALL be 1 in IDLE, and 1 in ACTIVE when rem==0; otherwise 0. flush=1 forces req_ready=0.
REQ-017 On accept with N>0 and stall=0: ce<=1, rem<=N-1, state<=ACTIVE; ce is high in the cycle after the accept edge.
REQ-018 On accept with N>0 and stall=1: ce<=0, rem<=N, state<=ACTIVE.
REQ-019 On accept with N==0: no ce, state unchanged from IDLE, done<=1 in the next cycle.
REQ-020 In ACTIVE with rem>0 and no accept: stall=0 -> ce<=1, rem<=rem-1; stall=1 -> ce<=0, rem held.
REQ-021 In ACTIVE with rem==0 (the final grant is in progress): done<=1 at the next edge regardless of stall.
REQ-021a In that case, with no accept, state<=IDLE and ce<=0.
REQ-022 Back-to-back: an accept at the edge where rem==0 SHALL apply REQ-017/018/019 to the new request and still assert done for the old one.
REQ-022a With stall=0 and N>0 on that accept, ce SHALL remain high with no gap.
REQ-023 For any request of N, ce SHALL be high for exactly N cycles, excluding cycles lost to flush.
REQ-024 done SHALL be 0 in every cycle not specified by REQ-019, REQ-021 or REQ-022.
REQ-025 flush=1 at an edge: ce<=0, rem<=0, state<=IDLE, no accept, done<=0; flush SHALL take priority over all other inputs.
REQ-026 granted_total SHALL increment by 1 at each edge where ce is 1; it SHALL wrap modulo 2^TOT_W without saturation.
REQ-027 req_cycles at its maximum of 2^CNT_W-1 SHALL be granted in full; rem SHALL never underflow.

Reset
REQ-028 reset_n=0 SHALL immediately force ce=0, done=0, busy=0, rem=0, granted_total=0 and state IDLE, independent of clock.
REQ-029 Reset asserted mid-request SHALL discard the request with no done pulse.
REQ-030 After reset_n deasserts, req_ready SHALL read 1 and the first accept SHALL be possible at the first rising edge.

Verification
REQ-031 Request N=5 with stall=0 -> ce high for 5 consecutive cycles starting one cycle after accept; done high one cycle later; granted_total=5.
REQ-032 N=4, with stall held high for 3 cycles after the second grant -> ce pattern 1,1,0,0,0,1,1; done follows the last 1; busy deasserts with done.
REQ-033 N=3 then N=2, with the second req_valid held continuously -> second accept at the rem==0 edge; ce high for 5 gapless cycles; two done pulses, the first overlapping ce.
REQ-034 N=0 -> ce never high; done pulse one cycle after accept; busy stays 0.
REQ-035 N=10, flush after 4 grants -> ce low the next cycle, no done, req_ready=1 after the flush; granted_total=4.
REQ-036 Two cases: (a) reset_n pulsed low mid-request -> ce drops asynchronously and all outputs read reset values. (b) TOT_W=4 with 17 grants -> granted_total=1.
